// File: rtl/div_norm_stage.sv
// div_norm_stage
//   Pre-normalization stage for the restoring array divider. Left-shifts the
//   divisor until its MSB is set and applies the same shift to a widened copy
//   of the dividend, so floor(XN/YN) == floor(X/Y). The shift count is passed
//   on so the remainder can be recovered downstream as R = RN >> SH.
//
//   Build option: define DIV_NORM_FAST_EN to replace the one-bit-per-cycle
//   SHIFT loop with a leading-zero count plus barrel shift in the accept
//   cycle (constant 1-cycle latency, identical output values).
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   X/Y valid            in_ready_o   stage can accept X/Y
//   X_i          dividend (widthX)    Y_i          divisor (widthY)
//   out_valid_o  result valid         out_ready_i  downstream accepts result
//   XN_o         {0s,X} << SH         YN_o         Y << SH (MSB set unless DBZ)
//   SH_o         shift count          DBZ_o        Y was zero
module div_norm_stage #(
    parameter int widthX = 16,
    parameter int widthY = 8,
    parameter int widthS = $clog2(widthY)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [widthX-1:0]        X_i,
    input  logic [widthY-1:0]        Y_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [widthX+widthY-1:0] XN_o,
    output logic [widthY-1:0]        YN_o,
    output logic [widthS-1:0]        SH_o,
    output logic                     DBZ_o
);

`ifdef DIV_NORM_FAST_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t state;

    logic [widthX+widthY-1:0] x_ext;
    assign x_ext = {{widthY{1'b0}}, X_i};

`ifdef DIV_NORM_FAST_EN
    // Leading-zero count of a non-zero divisor; zero input yields 0 so the
    // DBZ case carries SH = 0 just like the iterative build.
    function automatic logic [widthS-1:0] lzc(input logic [widthY-1:0] y);
        int  cnt;
        logic found;
        cnt   = 0;
        found = 1'b0;
        for (int i = widthY - 1; i >= 0; i--) begin
            if (!found) begin
                if (y[i]) found = 1'b1;
                else      cnt   = cnt + 1;
            end
        end
        if (!found) cnt = 0;
        return widthS'(cnt);
    endfunction

    logic [widthS-1:0] lz;
    assign lz = lzc(Y_i);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            XN_o        <= '0;
            YN_o        <= '0;
            SH_o        <= '0;
            DBZ_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        DBZ_o      <= (Y_i == '0);
                        in_ready_o <= 1'b0;
`ifdef DIV_NORM_FAST_EN
                        XN_o        <= x_ext << lz;
                        YN_o        <= Y_i << lz;
                        SH_o        <= lz;
                        state       <= DONE;
                        out_valid_o <= 1'b1;
`else
                        XN_o <= x_ext;
                        YN_o <= Y_i;
                        SH_o <= '0;
                        // Zero or already-normalized divisors skip the loop.
                        if (Y_i == '0 || Y_i[widthY-1]) begin
                            state       <= DONE;
                            out_valid_o <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
`endif
                    end
                end
`ifndef DIV_NORM_FAST_EN
                SHIFT: begin
                    YN_o <= YN_o << 1;
                    XN_o <= XN_o << 1;
                    SH_o <= SH_o + widthS'(1);
                    // Bit widthY-2 becomes the MSB after this shift.
                    if (YN_o[widthY-2]) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule
